// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet-sequencing controller.
package router_pkg;

  localparam int unsigned NUM_PORTS = 3;
  localparam int unsigned ADDR_W    = 2;
  localparam int unsigned STATE_W   = 3;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef logic [STATE_W-1:0] state_t;

  // Binary state encodings; DECODE_ADDRESS is the reset state.
  localparam state_t DECODE_ADDRESS     = 3'd0;
  localparam state_t LOAD_FIRST_DATA    = 3'd1;
  localparam state_t LOAD_DATA          = 3'd2;
  localparam state_t FIFO_FULL_STATE    = 3'd3;
  localparam state_t LOAD_AFTER_FULL    = 3'd4;
  localparam state_t LOAD_PARITY        = 3'd5;
  localparam state_t CHECK_PARITY_ERROR = 3'd6;
  localparam state_t WAIT_TILL_EMPTY    = 3'd7;

endpackage

// File: rtl/router_fsm.sv
// Packet-sequencing controller: steps the register block through header, payload,
// parity and full-stall phases and gates FIFO write enables by the latched address.
module router_fsm
  import router_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 full_state,
  output logic                 laf_state,
  output logic                 rst_int_reg,
  output logic                 write_enb_reg,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 busy
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          empty_ext;
  logic [3:0]          soft_ext;
  logic                soft_hit;

  // Pad to four entries so a 2-bit address never indexes out of range.
  assign empty_ext = {1'b0, fifo_empty};
  assign soft_ext  = {1'b0, soft_reset};
  assign soft_hit  = soft_ext[addr_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && (data_in != ADDR_INVALID)) begin
          addr_d  = data_in;
          state_d = empty_ext[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (empty_ext[addr_q]) state_d = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default: state_d = DECODE_ADDRESS;
    endcase
    // A read timeout on the selected FIFO abandons the packet from any active phase.
    if ((state_q != DECODE_ADDRESS) && soft_hit) state_d = DECODE_ADDRESS;
  end

  always_comb begin
    detect_add    = (state_q == DECODE_ADDRESS);
    lfd_state     = (state_q == LOAD_FIRST_DATA);
    ld_state      = (state_q == LOAD_DATA);
    full_state    = (state_q == FIFO_FULL_STATE);
    laf_state     = (state_q == LOAD_AFTER_FULL);
    rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    write_enb_reg = (state_q == LOAD_FIRST_DATA) || (state_q == LOAD_DATA) ||
                    (state_q == LOAD_AFTER_FULL) || (state_q == LOAD_PARITY);
    busy          = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);
    write_enb     = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      write_enb[i] = write_enb_reg && (addr_q == ADDR_W'(i));
    end
  end

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: each cycle's expected output vector is queued
// as inputs are driven and compared after the following rising edge.
module tb_router_fsm;

  logic       clock;
  logic       reset;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_reset;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg;
  logic       write_enb_reg, busy;
  logic [2:0] write_enb;

  int checks   = 0;
  int failures = 0;

  localparam int DA  = 0;
  localparam int LFD = 1;
  localparam int LD  = 2;
  localparam int FUL = 3;
  localparam int LAF = 4;
  localparam int LP  = 5;
  localparam int CPE = 6;
  localparam int WTE = 7;

  typedef struct {
    string       tag;
    logic [10:0] vec;
  } exp_t;

  exp_t sb_q[$];

  router_fsm dut (
    .clock         (clock),
    .reset         (reset),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .soft_reset    (soft_reset),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .full_state    (full_state),
    .laf_state     (laf_state),
    .rst_int_reg   (rst_int_reg),
    .write_enb_reg (write_enb_reg),
    .write_enb     (write_enb),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output vector {detect_add,lfd,ld,full,laf,rst_int,write_enb_reg,write_enb[2:0],busy}.
  function automatic logic [10:0] exp_vec(input int st, input logic [1:0] a);
    logic       wer;
    logic [2:0] we;
    logic       bsy;
    wer = (st == LFD) || (st == LD) || (st == LAF) || (st == LP);
    we  = 3'b000;
    if (wer && a != 2'b11) we = 3'b001 << a;
    bsy = !((st == DA) || (st == LD));
    return {st == DA, st == LFD, st == LD, st == FUL, st == LAF, st == CPE, wer, we, bsy};
  endfunction

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, obs, expv);
    end
  endtask

  // Queue the expectation, clock once, then pop and compare away from the edge.
  task automatic step(input string tag, input int st, input logic [1:0] a);
    exp_t e;
    e.tag = tag;
    e.vec = exp_vec(st, a);
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty got 0 expected 1", tag);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, {detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
                    write_enb_reg, write_enb, busy}, e.vec);
    end
  endtask

  initial begin
    reset = 1'b1; pkt_valid = 1'b0; data_in = 2'b00; fifo_full = 1'b0;
    fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
    step("reset", DA, 2'd0);
    reset = 1'b0;
    step("idle", DA, 2'd0);

    // Header to port 1 with empty FIFO, short payload, parity.
    pkt_valid = 1'b1; data_in = 2'b01;
    step("hdr1_lfd", LFD, 2'd1);
    data_in = 2'b10;
    step("hdr1_ld", LD, 2'd1);
    step("hdr1_ld_busy0", LD, 2'd1);
    pkt_valid = 1'b0;
    step("par_lp", LP, 2'd1);
    step("par_cpe", CPE, 2'd1);
    step("par_da", DA, 2'd1);

    // Invalid address 3 is dropped.
    pkt_valid = 1'b1; data_in = 2'b11;
    step("addr3_drop", DA, 2'd1);
    pkt_valid = 1'b0;
    step("addr3_idle", DA, 2'd1);

    // Header to port 2 while FIFO 2 still holds data.
    pkt_valid = 1'b1; data_in = 2'b10; fifo_empty = 3'b011;
    step("wait_enter", WTE, 2'd2);
    for (int i = 0; i < 4; i++) step("wait_hold", WTE, 2'd2);
    fifo_empty = 3'b111;
    step("wait_lfd", LFD, 2'd2);
    step("p2_ld", LD, 2'd2);
    fifo_full = 1'b1;
    step("full_enter", FUL, 2'd2);
    step("full_hold", FUL, 2'd2);
    fifo_full = 1'b0;
    step("laf", LAF, 2'd2);
    step("laf_to_ld", LD, 2'd2);
    fifo_full = 1'b1;
    step("full2", FUL, 2'd2);
    fifo_full = 1'b0; low_pkt_valid = 1'b1;
    step("laf2", LAF, 2'd2);
    pkt_valid = 1'b0;
    step("laf_to_lp", LP, 2'd2);
    low_pkt_valid = 1'b0;
    step("lp_cpe", CPE, 2'd2);
    step("cpe_da", DA, 2'd2);

    // Full and parity byte together in LOAD_DATA; full wins; then parity_done exit.
    pkt_valid = 1'b1; data_in = 2'b00;
    step("p0_lfd", LFD, 2'd0);
    step("p0_ld", LD, 2'd0);
    pkt_valid = 1'b0; fifo_full = 1'b1;
    step("full_prio", FUL, 2'd0);
    fifo_full = 1'b0;
    step("laf_p0", LAF, 2'd0);
    parity_done = 1'b1;
    step("laf_pdone_da", DA, 2'd0);
    parity_done = 1'b0;

    // CHECK_PARITY_ERROR with FIFO full stalls instead of returning.
    pkt_valid = 1'b1; data_in = 2'b01;
    step("p1_lfd", LFD, 2'd1);
    pkt_valid = 1'b0;
    step("p1_ld", LD, 2'd1);
    step("p1_lp", LP, 2'd1);
    fifo_full = 1'b1;
    step("p1_cpe", CPE, 2'd1);
    step("cpe_full", FUL, 2'd1);

    // Soft reset of a non-selected FIFO is ignored, selected one aborts.
    soft_reset = 3'b100;
    step("soft_other", FUL, 2'd1);
    soft_reset = 3'b010;
    step("soft_sel", DA, 2'd1);
    soft_reset = 3'b000; fifo_full = 1'b0;
    step("soft_idle", DA, 2'd1);

    // Reset mid-packet.
    pkt_valid = 1'b1; data_in = 2'b00;
    step("r_lfd", LFD, 2'd0);
    step("r_ld", LD, 2'd0);
    reset = 1'b1;
    step("reset_mid", DA, 2'd0);
    reset = 1'b0; pkt_valid = 1'b0;
    step("after_reset", DA, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
